// File: rtl/mcu_bus_sync.sv
// mcu_bus_sync: MCU multiplexed 8-bit bus slave with synchronised strobes, config/check regs,
// coherent multi-byte ADC reads and a saturating protocol error counter.
module mcu_bus_sync #(
    parameter int          N_CFG       = 5,
    parameter logic [7:0]  CFG_BASE    = 8'h50,
    parameter int          N_ADC       = 8,
    parameter int          ADC_W       = 16,
    parameter logic [7:0]  ADC_BASE    = 8'h10,
    parameter logic [7:0]  CHK_ADDR    = 8'hAA,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               db_i,
    output logic [7:0]               db_o,
    output logic                     db_oe,
    input  logic                     ale_n,
    input  logic                     wr_n,
    input  logic                     rd_n,
    output logic [8*N_CFG-1:0]       cfg_regs,
    output logic [N_CFG-1:0]         cfg_wr_stb,
    input  logic [ADC_W*N_ADC-1:0]   ad_data,
    output logic [7:0]               err_cnt
);
    localparam int B       = ADC_W / 8;
    localparam int CFG_LO  = int'(CFG_BASE);
    localparam int CFG_END = CFG_LO + N_CFG;
    localparam int ADC_LO  = int'(ADC_BASE);
    localparam int ADC_END = ADC_LO + N_ADC * B;
    localparam int CHK     = int'(CHK_ADDR);

    if (ADC_W % 8 != 0 || ADC_W < 8 || ADC_W > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 3)
        begin : g_bad_param
        $error("mcu_bus_sync: ADC_W or SYNC_STAGES out of range");
    end
    if (ADC_END > 256 || CFG_END > 256 || (CFG_LO < ADC_END && ADC_LO < CFG_END) ||
        (CHK >= CFG_LO && CHK < CFG_END) || (CHK >= ADC_LO && CHK < ADC_END))
        begin : g_bad_map
        $error("mcu_bus_sync: address ranges overlap or exceed 8 bits");
    end

    logic [SYNC_STAGES-1:0]      ale_q, wr_q, rd_q;
    logic [SYNC_STAGES-1:0][7:0] db_q;
    logic                        wr_p_q, rd_p_q;
    logic                        armed_q, taint_q;
    logic [7:0]                  addr_q, wdata_q, chk_q, err_q, db_o_q;
    logic                        db_oe_q;
    logic [N_CFG-1:0][7:0]       cfg_q;
    logic [N_CFG-1:0]            stb_q;
    logic [ADC_W-1:0]            shadow_q;

    logic                        ale_s, wr_s, rd_s;
    logic [7:0]                  db_s;
    logic                        wr_rise, rd_fall, rd_rise, coll, coll_onset;
    logic                        wr_ok, rd_go, ale_err, bad_wr, bad_rd, err_inc;
    logic [N_CFG-1:0]            cfg_sel;
    logic                        chk_sel, rd_hit, snap_ld;
    logic [7:0]                  rd_val, err_d;
    logic [ADC_W-1:0]            snap_val;

    assign ale_s = ale_q[SYNC_STAGES-1];
    assign wr_s  = wr_q[SYNC_STAGES-1];
    assign rd_s  = rd_q[SYNC_STAGES-1];
    assign db_s  = db_q[SYNC_STAGES-1];

    assign wr_rise    = wr_s & ~wr_p_q;
    assign rd_fall    = ~rd_s & rd_p_q;
    assign rd_rise    = rd_s & ~rd_p_q;
    assign coll       = ~wr_s & ~rd_s;
    assign coll_onset = coll & ~(~wr_p_q & ~rd_p_q);

    // armed_q keeps the bus idle after reset until the MCU issues a fresh ALE;
    // taint_q vetoes the commit of any write strobe that overlapped a read strobe.
    assign wr_ok   = wr_rise & ale_s & rd_s & armed_q & ~taint_q;
    assign rd_go   = rd_fall & ale_s & wr_s & armed_q;
    assign ale_err = ~ale_s & (wr_rise | rd_fall);
    assign bad_wr  = wr_ok & ~(|cfg_sel) & ~chk_sel;
    assign bad_rd  = rd_go & ~rd_hit;
    assign err_inc = bad_wr | bad_rd | coll_onset | ale_err;
    assign err_d   = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_comb begin
        cfg_sel  = '0;
        rd_val   = 8'hFF;
        rd_hit   = 1'b0;
        snap_ld  = 1'b0;
        snap_val = shadow_q;
        for (int k = 0; k < N_CFG; k++) begin
            cfg_sel[k] = addr_q == 8'(CFG_LO + k);
            if (cfg_sel[k]) begin
                rd_val = cfg_q[k];
                rd_hit = 1'b1;
            end
        end
        chk_sel = addr_q == CHK_ADDR;
        if (chk_sel) begin
            rd_val = chk_q;
            rd_hit = 1'b1;
        end
        for (int k = 0; k < N_ADC; k++) begin
            for (int j = 0; j < B; j++) begin
                if (addr_q == 8'(ADC_LO + k * B + j)) begin
                    rd_hit = 1'b1;
                    rd_val = (j == 0) ? ad_data[ADC_W*k +: 8] : shadow_q[8*j +: 8];
                    if (j == 0) begin
                        snap_ld  = 1'b1;
                        snap_val = ad_data[ADC_W*k +: ADC_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ale_q    <= '1;
            wr_q     <= '1;
            rd_q     <= '1;
            db_q     <= '0;
            wr_p_q   <= 1'b1;
            rd_p_q   <= 1'b1;
            armed_q  <= 1'b0;
            taint_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            chk_q    <= '0;
            err_q    <= '0;
            db_o_q   <= '0;
            db_oe_q  <= 1'b0;
            cfg_q    <= '0;
            stb_q    <= '0;
            shadow_q <= '0;
        end else begin
            ale_q    <= {ale_q[SYNC_STAGES-2:0], ale_n};
            wr_q     <= {wr_q[SYNC_STAGES-2:0], wr_n};
            rd_q     <= {rd_q[SYNC_STAGES-2:0], rd_n};
            db_q     <= {db_q[SYNC_STAGES-2:0], db_i};
            wr_p_q   <= wr_s;
            rd_p_q   <= rd_s;
            armed_q  <= armed_q | ~ale_s;
            taint_q  <= coll ? 1'b1 : (wr_s & rd_s) ? 1'b0 : taint_q;
            addr_q   <= ~ale_s ? db_s : addr_q;
            wdata_q  <= ~wr_s ? db_s : wdata_q;
            err_q    <= err_d;
            stb_q    <= wr_ok ? cfg_sel : '0;
            chk_q    <= (wr_ok & chk_sel) ? wdata_q : chk_q;
            for (int k = 0; k < N_CFG; k++)
                cfg_q[k] <= (wr_ok & cfg_sel[k]) ? wdata_q : cfg_q[k];
            shadow_q <= (rd_go & snap_ld) ? snap_val : shadow_q;
            db_o_q   <= rd_go ? rd_val : db_o_q;
            db_oe_q  <= (coll | ~ale_s | rd_rise) ? 1'b0 : rd_go ? 1'b1 : db_oe_q;
        end
    end

    assign db_o       = db_o_q;
    assign db_oe      = db_oe_q;
    assign cfg_regs   = cfg_q;
    assign cfg_wr_stb = stb_q;
    assign err_cnt    = err_q;
endmodule
